i2s_tx_sequencer: RTL and testbench

- Sequences the I2S0 transmit datapath behind the I2S Avalon bus interface.
- The bus interface pushes stereo sample frames into this block's internal FIFO.
- The block generates MCLK, SCLK and LRCK, and shifts samples out MSB-first in standard I2S format: data is delayed one SCLK period after each LRCK edge.
- It reports FIFO level, busy state and underflow back to the bus interface's status registers.

---
 rtl/i2s_tx_sequencer_pkg.sv | 15 +
 rtl/i2s_tx_sequencer_if.sv | 32 +++
 rtl/i2s_tx_sequencer_sample_fifo.sv | 59 +++++
 rtl/i2s_tx_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_i2s_tx_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_tx_sequencer_pkg.sv
// Shared definitions for the I2S transmit sequencer: default sizes and FSM encoding.
package i2s_tx_sequencer_pkg;

   localparam int SAMPLE_BITS_DEF = 16;
   localparam int FIFO_DEPTH_DEF  = 8;
   localparam int MCLK_HALF_DEF   = 2;
   localparam int FRAME_BITS_DEF  = 2 * SAMPLE_BITS_DEF;

   // IDLE: serial outputs parked low.  RUN: bit clock running, frames shifting.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

endpackage

// File: rtl/i2s_tx_sequencer_if.sv
// Bus-side signals between the I2S Avalon register block and the transmit sequencer.
//
// Handshake: a frame is transferred on every rising clock edge where
// i_SampleValid && o_SampleReady.  o_SampleReady depends only on the FIFO
// level, never on i_SampleValid, and i_SampleData must be stable while
// i_SampleValid is high.
interface i2s_tx_sequencer_if
   import i2s_tx_sequencer_pkg::*;
#(
   parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
);
   logic                         i_Enable;
   logic [7:0]                   i_SclkDiv;
   logic                         i_SampleValid;
   logic [2*SAMPLE_BITS-1:0]     i_SampleData;
   logic                         o_SampleReady;
   logic [$clog2(FIFO_DEPTH):0]  o_FifoLevel;
   logic                         o_Busy;
   logic                         o_Underflow;
   logic                         i_ClearUnderflow;

   modport master (
      output i_Enable, i_SclkDiv, i_SampleValid, i_SampleData, i_ClearUnderflow,
      input  o_SampleReady, o_FifoLevel, o_Busy, o_Underflow
   );

   modport slave (
      input  i_Enable, i_SclkDiv, i_SampleValid, i_SampleData, i_ClearUnderflow,
      output o_SampleReady, o_FifoLevel, o_Busy, o_Underflow
   );
endinterface

// File: rtl/i2s_tx_sequencer_sample_fifo.sv
// Synchronous stereo-frame FIFO; a read of an empty FIFO returns zeros.
module i2s_sample_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q,  level_d;
   logic             do_push, do_pop;

   assign full_o     = (level_q == LW'(DEPTH));
   assign empty_o    = (level_q == '0);
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign level_o    = level_q;

   // Pointer and level bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
   end

   // Pointer/level registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S0 transmit sequencer: buffers stereo frames and serialises them in
// standard I2S format (data one SCLK behind LRCK), with MCLK generation.
module i2s_tx_sequencer
   import i2s_tx_sequencer_pkg::*;
#(
   parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int MCLK_HALF   = MCLK_HALF_DEF
) (
   input  logic               i_Clk,
   input  logic               i_Reset,
   i2s_tx_sequencer_if.slave  bus,
   output logic               o_I2S0_SDIN,
   output logic               o_I2S0_SCLK,
   output logic               o_I2S0_LRCK,
   output logic               o_I2S0_MCLK
);
   localparam int FW  = 2 * SAMPLE_BITS;
   localparam int BCW = $clog2(FW);
   localparam int MCW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

   seq_state_e     state_q, state_d;
   logic [7:0]     div_q, div_d;
   logic [7:0]     div_cnt_q, div_cnt_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic           sclk_q, sclk_d;
   logic           lrck_q, lrck_d;
   logic           sdin_q, sdin_d;
   logic [FW-1:0]  shift_q, shift_d;
   logic [FW-1:0]  shadow_q, shadow_d;
   logic           stop_q, stop_d;
   logic           underflow_q, underflow_d;
   logic [MCW-1:0] mclk_cnt_q;
   logic           mclk_q;

   logic           pop, push;
   logic [FW-1:0]  fifo_data;
   logic           fifo_full, fifo_empty;

   assign push              = bus.i_SampleValid && !fifo_full;
   assign bus.o_SampleReady = !fifo_full;
   assign bus.o_Busy        = (state_q == ST_RUN);
   assign bus.o_Underflow   = underflow_q;
   assign o_I2S0_SDIN       = sdin_q;
   assign o_I2S0_SCLK       = sclk_q;
   assign o_I2S0_LRCK       = lrck_q;
   assign o_I2S0_MCLK       = mclk_q;

   i2s_sample_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (i_Clk),
      .rst_i       (i_Reset),
      .push_i      (push),
      .push_data_i (bus.i_SampleData),
      .pop_i       (pop),
      .pop_data_o  (fifo_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (bus.o_FifoLevel)
   );

   // Next-state: SCLK divider, bit sequencing, frame-boundary pops and graceful stop.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      sclk_d    = sclk_q;
      lrck_d    = lrck_q;
      sdin_d    = sdin_q;
      shift_d   = shift_q;
      shadow_d  = shadow_q;
      stop_d    = stop_q;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sclk_d = 1'b0;
            lrck_d = 1'b0;
            sdin_d = 1'b0;
            stop_d = 1'b0;
            if (bus.i_Enable) begin
               div_d     = bus.i_SclkDiv;
               pop       = 1'b1;
               shadow_d  = fifo_data;
               div_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (div_cnt_q == div_q) begin
               div_cnt_d = '0;
               sclk_d    = ~sclk_q;
               if (sclk_q) begin
                  // Falling SCLK edge: one bit slot ends, the next begins.
                  if (stop_q) begin
                     state_d   = ST_IDLE;
                     sdin_d    = 1'b0;
                     lrck_d    = 1'b0;
                     bit_cnt_d = '0;
                     stop_d    = 1'b0;
                  end else begin
                     if (bit_cnt_q == '0) begin
                        sdin_d  = shadow_q[FW-1];
                        shift_d = shadow_q << 1;
                     end else begin
                        sdin_d  = shift_q[FW-1];
                        shift_d = shift_q << 1;
                     end
                     if (bit_cnt_q == BCW'(SAMPLE_BITS - 1)) lrck_d = 1'b1;
                     if (bit_cnt_q == BCW'(FW - 1)) begin
                        // Last right bit goes out now: frame boundary.
                        lrck_d    = 1'b0;
                        bit_cnt_d = '0;
                        if (bus.i_Enable) begin
                           pop      = 1'b1;
                           shadow_d = fifo_data;
                        end else begin
                           stop_d   = 1'b1;
                        end
                     end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                     end
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Set wins over clear so an underflow is never lost.
      underflow_d = (pop && fifo_empty) ? 1'b1 :
                    (bus.i_ClearUnderflow ? 1'b0 : underflow_q);
   end

   // Sequencer state register.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         sclk_q      <= 1'b0;
         lrck_q      <= 1'b0;
         sdin_q      <= 1'b0;
         shift_q     <= '0;
         shadow_q    <= '0;
         stop_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sclk_q      <= sclk_d;
         lrck_q      <= lrck_d;
         sdin_q      <= sdin_d;
         shift_q     <= shift_d;
         shadow_q    <= shadow_d;
         stop_q      <= stop_d;
         underflow_q <= underflow_d;
      end
   end

   // Free-running MCLK, independent of the sequencer state.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         mclk_cnt_q <= '0;
         mclk_q     <= 1'b0;
      end else if (mclk_cnt_q == MCW'(MCLK_HALF - 1)) begin
         mclk_cnt_q <= '0;
         mclk_q     <= ~mclk_q;
      end else begin
         mclk_cnt_q <= mclk_cnt_q + MCW'(1);
      end
   end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for the I2S transmit sequencer with a frame-queue reference model.
module tb_i2s_tx_sequencer;

   localparam int N     = 16;
   localparam int DEPTH = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sdin, sclk, lrck, mclk;

   always #5 clk = ~clk;

   i2s_tx_sequencer_if #(.SAMPLE_BITS(N), .FIFO_DEPTH(DEPTH)) bus ();

   i2s_tx_sequencer #(.SAMPLE_BITS(N), .FIFO_DEPTH(DEPTH), .MCLK_HALF(2)) dut (
      .i_Clk       (clk),
      .i_Reset     (rst),
      .bus         (bus),
      .o_I2S0_SDIN (sdin),
      .o_I2S0_SCLK (sclk),
      .o_I2S0_LRCK (lrck),
      .o_I2S0_MCLK (mclk)
   );

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];
   logic [31:0] exp_shadow;
   logic        exp_uf;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Step to just after the next active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference FIFO pop: empty yields zeros and raises the underflow flag.
   task automatic model_pop();
      if (exp_q.size() > 0) exp_shadow = exp_q.pop_front();
      else begin
         exp_shadow = '0;
         exp_uf     = 1'b1;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_sdin"},  sdin, 0);
      check_eq({tag, "_sclk"},  sclk, 0);
      check_eq({tag, "_lrck"},  lrck, 0);
      check_eq({tag, "_mclk"},  mclk, 0);
      check_eq({tag, "_busy"},  bus.o_Busy, 0);
      check_eq({tag, "_uf"},    bus.o_Underflow, 0);
      check_eq({tag, "_ready"}, bus.o_SampleReady, 1);
      check_eq({tag, "_level"}, bus.o_FifoLevel, 0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      bus.i_Enable         = 1'b0;
      bus.i_SclkDiv        = 8'd0;
      bus.i_SampleValid    = 1'b0;
      bus.i_SampleData     = '0;
      bus.i_ClearUnderflow = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      exp_uf = 1'b0;
      check_reset_vals("reset");
   endtask

   task automatic push_frame(input logic [31:0] d);
      bit accept;
      accept = (exp_q.size() < DEPTH);
      check_eq("ready", bus.o_SampleReady, 32'(accept));
      bus.i_SampleValid = 1'b1;
      bus.i_SampleData  = d;
      tick();
      bus.i_SampleValid = 1'b0;
      if (accept) exp_q.push_back(d);
      check_eq("push_level", bus.o_FifoLevel, exp_q.size());
   endtask

   task automatic clear_uf();
      bus.i_ClearUnderflow = 1'b1;
      tick();
      bus.i_ClearUnderflow = 1'b0;
      exp_uf = 1'b0;
      check_eq("uf_clear", bus.o_Underflow, 0);
   endtask

   // Raise Enable; the edge taken here is cycle 0 of the run.
   task automatic start_run(input int div, input bit clr);
      bit was_empty;
      was_empty = (exp_q.size() == 0);
      bus.i_SclkDiv        = 8'(div);
      bus.i_Enable         = 1'b1;
      bus.i_ClearUnderflow = clr;
      tick();
      bus.i_ClearUnderflow = 1'b0;
      model_pop();
      if (clr && !was_empty) exp_uf = 1'b0;
      check_eq("entry_busy",  bus.o_Busy, 1);
      check_eq("entry_level", bus.o_FifoLevel, exp_q.size());
      check_eq("entry_uf",    bus.o_Underflow, 32'(exp_uf));
   endtask

   // Walk one 2N-bit frame from its starting edge; optionally drop Enable
   // after falling edge drop_f, and optionally push on the boundary edge.
   task automatic check_frame(input int div, input int drop_f,
                              input bit bpush, input logic [31:0] bdata);
      logic [31:0] cur;
      bit          accept;
      cur = exp_shadow;
      for (int f = 1; f <= 2 * N; f++) begin
         repeat (div + 1) tick();
         check_eq($sformatf("rise%0d", f), sclk, 1);
         accept = 1'b0;
         if (f == 2 * N && bpush) begin
            accept = (exp_q.size() < DEPTH);
            repeat (div) tick();
            bus.i_SampleValid = 1'b1;
            bus.i_SampleData  = bdata;
            tick();
            bus.i_SampleValid = 1'b0;
         end else begin
            repeat (div + 1) tick();
         end
         check_eq($sformatf("fall%0d", f),  sclk, 0);
         check_eq($sformatf("sdin%0d", f),  sdin, 32'(cur[2*N-f]));
         check_eq($sformatf("lrck%0d", f),  lrck, 32'((f >= N) && (f < 2 * N)));
         check_eq($sformatf("busy%0d", f),  bus.o_Busy, 1);
         if (f == 2 * N) begin
            if (bus.i_Enable) model_pop();
            if (accept) exp_q.push_back(bdata);
            check_eq("bnd_level", bus.o_FifoLevel, exp_q.size());
            check_eq("bnd_uf",    bus.o_Underflow, 32'(exp_uf));
         end
         if (f == drop_f) bus.i_Enable = 1'b0;
      end
   endtask

   // After a frame with Enable low at its boundary: one more rise, then IDLE.
   task automatic check_stop(input int div);
      repeat (div + 1) tick();
      check_eq("stop_rise", sclk, 1);
      check_eq("stop_busy_before", bus.o_Busy, 1);
      repeat (div + 1) tick();
      check_eq("stop_busy", bus.o_Busy, 0);
      check_eq("stop_sclk", sclk, 0);
      check_eq("stop_sdin", sdin, 0);
      check_eq("stop_lrck", lrck, 0);
      check_eq("stop_level", bus.o_FifoLevel, exp_q.size());
      repeat (6) tick();
      check_eq("idle_sclk", sclk, 0);
      check_eq("idle_busy", bus.o_Busy, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Basic frame, plus MCLK cadence straight out of reset.
      do_reset();
      for (int j = 1; j <= 8; j++) begin
         tick();
         check_eq($sformatf("mclk%0d", j), mclk, 32'((j / 2) % 2));
      end
      push_frame(32'hA5A5_0F0F);
      start_run(1, 1'b0);
      check_frame(1, 20, 1'b0, '0);
      check_stop(1);

      // Underflow, clear, and clear coincident with a fresh underflow.
      do_reset();
      start_run(1, 1'b0);
      check_frame(1, 20, 1'b0, '0);
      check_stop(1);
      clear_uf();
      start_run(1, 1'b1);
      // Push landing on an empty-FIFO pop is stored, not forwarded.
      check_frame(1, 0, 1'b1, 32'h5555_AAAA);
      check_frame(1, 20, 1'b0, '0);
      check_stop(1);
      clear_uf();

      // Graceful stop leaves the second frame queued.
      do_reset();
      push_frame(32'h1234_5678);
      push_frame(32'h9ABC_DEF0);
      start_run(1, 1'b0);
      check_frame(1, 10, 1'b0, '0);
      check_stop(1);
      check_eq("stop_uf", bus.o_Underflow, 0);
      start_run(1, 1'b0);
      check_frame(1, 5, 1'b0, '0);
      check_stop(1);

      // FIFO full, then back-to-back drain at SclkDiv=0.
      do_reset();
      for (int i = 0; i <= DEPTH; i++) push_frame(32'h8000_0001 ^ (i * 32'h1357_9BDF));
      bus.i_SampleValid = 1'b1;
      bus.i_SampleData  = 32'hDEAD_BEEF;
      start_run(0, 1'b0);
      bus.i_SampleValid = 1'b0;
      bus.i_SclkDiv     = 8'd7;
      for (int k = 0; k <= DEPTH; k++) begin
         check_frame(0, (k == DEPTH) ? 5 : 0, k == 2, 32'h0BAD_F00D);
      end
      check_stop(0);
      check_eq("drain_uf", bus.o_Underflow, 0);

      // Reset in the middle of a frame, then a clean restart.
      do_reset();
      push_frame(32'hCAFE_0001);
      push_frame(32'hCAFE_0002);
      start_run(1, 1'b0);
      repeat (39) tick();
      rst = 1'b1;
      bus.i_Enable = 1'b0;
      tick();
      rst = 1'b0;
      exp_q.delete();
      exp_uf = 1'b0;
      check_reset_vals("midreset");
      push_frame(32'h3C3C_C3C3);
      start_run(1, 1'b0);
      check_frame(1, 3, 1'b0, '0);
      check_stop(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
